// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: loader state encoding and word/byte sizing shared by the prog_mem files.
package prog_mem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} ld_state_e;
  localparam int BYTE_W = 8;
  function automatic int bytes_per_word(input int dw);
    return dw / BYTE_W;
  endfunction
endpackage

// File: rtl/prog_mem_dual_ram.sv
// dual_ram: one write port with byte strobes, one registered read port returning pre-write data.
module dual_ram #(
  parameter int DW = 32,
  parameter int DEPTH = 4096,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [DW/8-1:0] ws,
  input  logic          re,
  input  logic [IW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (re) rd <= mem[ra];
    if (we)
      for (int i = 0; i < DW/8; i++)
        if (ws[i]) mem[wa][i*8 +: 8] <= wd[i*8 +: 8];
  end
endmodule

// File: rtl/prog_mem.sv
// prog_mem: byte-strobed program memory with a little-endian byte-stream loader.
// Define PROG_MEM_CHKSUM_EN to accumulate ld_sum over loader-written words.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MEM_NUM = 4096
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ren,
  input  logic [AW-1:0]   r_addr,
  output logic [DW-1:0]   r_data,
  output logic            r_valid,
  input  logic            wen,
  input  logic [AW-1:0]   w_addr,
  input  logic [DW-1:0]   w_data,
  input  logic [DW/8-1:0] w_strb,
  input  logic            ld_start,
  input  logic [AW-1:0]   ld_base,
  input  logic            ld_valid,
  input  logic [7:0]      ld_byte,
  input  logic            ld_last,
  output logic            ld_ready,
  output logic            ld_busy,
  output logic            ld_done,
  output logic            err,
  output logic [DW-1:0]   ld_sum
);
  localparam int BPW = bytes_per_word(DW);
  localparam int OFF = $clog2(BPW);
  localparam int IW  = $clog2(MEM_NUM);
  localparam int CW  = $clog2(BPW + 1);

  function automatic logic oob(input logic [AW-1:0] a);
    return (a >> OFF) >= AW'(MEM_NUM);
  endfunction

  ld_state_e state, nxt;
  logic [AW-1:0] ptr, pend_a;
  logic [CW-1:0] cnt;
  logic [DW-1:0] pack, word_n, ld_wd, pend_d, ram_rd;
  logic pend, full, accept, ld_wr, rv_q, roob_q;

  assign full   = cnt == CW'(BPW - 1);
  assign accept = ld_valid && ld_ready;
  assign word_n = pack | (DW'(ld_byte) << (cnt * 8));
  assign ld_wr  = (accept && full) || state == FLUSH;
  assign ld_wd  = state == FLUSH ? pack : word_n;

  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    ld_ready = 1'b0;
    ld_busy = 1'b0;
    ld_done = 1'b0;
    case (state)
      IDLE: nxt = ld_start ? LOAD : IDLE;
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy = 1'b1;
        if (ld_valid && ld_last) nxt = full ? DONE : FLUSH;
      end
      FLUSH: begin
        ld_busy = 1'b1;
        nxt = DONE;
      end
      default: begin
        ld_busy = 1'b1;
        ld_done = 1'b1;
        nxt = IDLE;
      end
    endcase
  end

  // pack holds only accepted bytes, so a flushed word is already zero-filled
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
      cnt <= '0;
      pack <= '0;
      pend <= 1'b0;
    end else begin
      pend <= ld_wr;
      if (ld_wr) begin
        pend_a <= ptr;
        pend_d <= ld_wd;
        ptr <= ptr + AW'(BPW);
        cnt <= '0;
        pack <= '0;
      end else if (state == IDLE && ld_start) begin
        ptr <= (ld_base >> OFF) << OFF;
        cnt <= '0;
        pack <= '0;
      end else if (accept) begin
        pack <= word_n;
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef PROG_MEM_CHKSUM_EN
  logic [DW-1:0] sum;
  always_ff @(posedge clk)
    if (!rstn) sum <= '0;
    else if (state == IDLE && ld_start) sum <= '0;
    else if (ld_wr && !oob(ptr)) sum <= sum + ld_wd;
  assign ld_sum = sum;
`else
  assign ld_sum = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rv_q <= 1'b0;
      roob_q <= 1'b0;
      err <= 1'b0;
    end else begin
      rv_q <= ren;
      roob_q <= ren && oob(r_addr);
      err <= (ren && oob(r_addr)) || (!ld_busy && wen && oob(w_addr)) || (ld_busy && pend && oob(pend_a));
    end
  end

  assign r_valid = rv_q;
  assign r_data  = (rv_q && !roob_q) ? ram_rd : '0;

  dual_ram #(.DW(DW), .DEPTH(MEM_NUM), .IW(IW)) u_ram (
    .clk(clk),
    .we (ld_busy ? (pend && !oob(pend_a)) : (wen && !oob(w_addr))),
    .wa (ld_busy ? IW'(pend_a >> OFF) : IW'(w_addr >> OFF)),
    .wd (ld_busy ? pend_d : w_data),
    .ws (ld_busy ? {(DW/8){1'b1}} : w_strb),
    .re (ren && !oob(r_addr)),
    .ra (IW'(r_addr >> OFF)),
    .rd (ram_rd)
  );
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: random and directed traffic against a word-array model; reads and err scored by a negedge monitor.
module tb_prog_mem;
  localparam bit CHK = `ifdef PROG_MEM_CHKSUM_EN 1'b1 `else 1'b0 `endif;

  logic clk = 0, rstn = 0;
  logic ren = 0, wen = 0, ld_start = 0, ld_valid = 0, ld_last = 0;
  logic [31:0] r_addr = 0, w_addr = 0, w_data = 0, ld_base = 0;
  logic [3:0] w_strb = 0;
  logic [7:0] ld_byte = 0;
  logic [31:0] r_data, ld_sum;
  logic r_valid, ld_ready, ld_busy, ld_done, err;

  prog_mem dut (
    .clk(clk), .rstn(rstn), .ren(ren), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
    .wen(wen), .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .err(err), .ld_sum(ld_sum)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] d; } rd_t;
  rd_t rd_q[$];
  bit err_exp[int];
  logic [31:0] model [4096];
  logic [7:0] lb[$];
  int cyc = 0, total = 0, bad = 0, done_cnt = 0, lderr_cnt = 0;
  bit mon_on = 0, in_load = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit oobw(input logic [31:0] a);
    return (a >> 2) >= 4096;
  endfunction

  always @(negedge clk) if (mon_on) begin
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      chk("r_valid", r_valid, 1);
      chk("r_data", r_data, rd_q[0].d);
      void'(rd_q.pop_front());
    end else chk("r_idle", {r_valid, r_data}, 0);
    if (!in_load) chk("err", err, 64'(err_exp.exists(cyc)));
    if (ld_done) done_cnt++;
    if (in_load && err) lderr_cnt++;
  end

  task automatic do_cycle(input logic r, input logic [31:0] ra, input logic w,
                          input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
    int n = cyc + 1;
    ren = r; r_addr = ra; wen = w; w_addr = wa; w_data = wd; w_strb = ws;
    if (r) begin
      rd_q.push_back('{n, oobw(ra) ? 32'h0 : model[ra >> 2]});
      if (oobw(ra)) err_exp[n] = 1;
    end
    if (w) begin
      if (oobw(wa)) err_exp[n] = 1;
      else for (int b = 0; b < 4; b++) if (ws[b]) model[wa >> 2][8*b +: 8] = wd[8*b +: 8];
    end
    step();
    ren = 0; wen = 0;
  endtask

  task automatic do_load(input logic [31:0] base, input int stop_at);
    int d0, e0, exp_err, widx;
    logic [31:0] exp_sum, w;
    bit ok;
    in_load = 1; d0 = done_cnt; e0 = lderr_cnt;
    ld_base = base; ld_start = 1; step(); ld_start = 0;
    foreach (lb[i]) begin
      ld_valid = 0;
      repeat ($urandom_range(0, 2)) step();
      ld_valid = 1; ld_byte = lb[i]; ld_last = (i == lb.size() - 1);
      if (i == 0) begin wen = 1; w_addr = 32'h0C; w_data = $urandom; w_strb = 4'hF; end
      ok = 0;
      for (int k = 0; k < 10 && !ok; k++) begin ok = ld_ready; step(); end
      wen = 0;
      if (!ok) chk("ld_ready_timeout", 0, 1);
      if (i + 1 == stop_at) begin
        ld_valid = 0; ld_last = 0; rstn = 0; step();
        chk("rst_mid_rd", {r_valid, r_data}, 0);
        chk("rst_mid_ld", {ld_ready, ld_busy, ld_done, err}, 0);
        chk("rst_mid_sum", ld_sum, 0);
        rstn = 1; step(); in_load = 0;
        return;
      end
    end
    ld_valid = 0; ld_last = 0;
    exp_sum = 0; exp_err = 0;
    for (int j = 0; j < (lb.size() + 3) / 4; j++) begin
      w = 0;
      for (int b = 0; b < 4; b++) if (4*j + b < lb.size()) w[8*b +: 8] = lb[4*j + b];
      widx = int'(base >> 2) + j;
      if (widx >= 4096) exp_err++;
      else begin model[widx] = w; exp_sum += w; end
    end
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) if (ld_done) ok = 1; else step();
    chk("ld_done_seen", ok, 1);
    if (ok) chk("ld_sum", ld_sum, CHK ? exp_sum : 32'h0);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) if (!ld_busy) ok = 1; else step();
    chk("ld_busy_clear", ok, 1);
    repeat (2) step();
    chk("ld_done_pulses", done_cnt - d0, 1);
    chk("ld_err_pulses", lderr_cnt - e0, exp_err);
    in_load = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_ld_busy", ld_busy, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_err", err, 0);
    chk("rst_ld_sum", ld_sum, 0);
    rstn = 1; mon_on = 1;
    for (int i = 0; i < 64; i++) do_cycle(0, 0, 1, i * 4, 0, 4'hF);
    do_cycle(0, 0, 1, 32'h3FFC, 0, 4'hF);
    do_cycle(0, 0, 1, 32'h8, 32'hAABBCCDD, 4'b0101);
    do_cycle(1, 32'h8, 0, 0, 0, 0);
    do_cycle(1, 32'h4000, 0, 0, 0, 0);
    do_cycle(0, 0, 1, 32'h4004, 32'h1234, 4'hF);
    do_cycle(1, 32'h20, 1, 32'h20, 32'hCAFEF00D, 4'hF);
    do_cycle(1, 32'h22, 1, 32'h21, 32'h11111111, 4'h0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, wa;
      ra = ($urandom_range(0, 11) == 0) ? (32'h4000 | $urandom) : ($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      wa = ($urandom_range(0, 11) == 0) ? (32'h4000 | $urandom) : ($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      do_cycle(1'($urandom), ra, 1'($urandom), wa, $urandom, 4'($urandom));
    end
    lb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_load(32'h10, -1);
    do_cycle(1, 32'h10, 0, 0, 0, 0);
    do_cycle(1, 32'h14, 0, 0, 0, 0);
    lb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_load(32'h40, -1);
    for (int t = 0; t < 5; t++) begin
      lb.delete();
      repeat ($urandom_range(1, 12)) lb.push_back(8'($urandom));
      do_load(($urandom_range(24, 50) * 4) | $urandom_range(0, 3), -1);
    end
    lb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_load(32'h3FFC, -1);
    lb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_load(32'h80, 2);
    for (int i = 0; i < 64; i++) do_cycle(1, i * 4, 0, 0, 0, 0);
    do_cycle(1, 32'h3FFC, 0, 0, 0, 0);
    repeat (3) step();
    chk("rd_q_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter DW, default 32: data word width in bits; multiple of 8.
REQ-002 SHALL have parameter AW, default 32: byte address width.
REQ-003 SHALL have parameter MEM_NUM, default 4096: depth in words.
REQ-004 SHALL have ports clk (input, 1, sole clock) and rstn (input, 1); one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports ren (input, 1), r_addr (input, AW, byte address) and r_data (output, DW).
REQ-006 SHALL have port r_valid (output, 1): r_data qualifier.
REQ-007 SHALL have ports wen (input, 1), w_addr (input, AW), w_data (input, DW) and w_strb (input, DW/8, byte enables).
REQ-008 SHALL have ports ld_start (input, 1) and ld_base (input, AW, load start byte address).
REQ-009 SHALL have ports ld_valid (input, 1), ld_byte (input, 8), ld_last (input, 1) and ld_ready (output, 1).
REQ-010 SHALL have ports ld_busy (output, 1), ld_done (output, 1, pulse) and err (output, 1, pulse).
REQ-011 SHALL have port ld_sum (output, DW, load checksum).

Function
REQ-012 SHALL address memory by word index = address[AW-1:$clog2(DW/8)]; low address bits ignored.
REQ-013 SHALL assert r_valid exactly 1 cycle after an accepted ren, with r_data = word at r_addr; r_valid and r_data hold 0 otherwise.
REQ-014 SHALL return old data on read of a word written in the same cycle.
REQ-015 SHALL write only the bytes whose w_strb bit is 1; wen with w_strb = 0 changes nothing.
REQ-016 SHALL, for a word index >= MEM_NUM: drop the write; or return r_data = 0 with r_valid = 1; in both cases pulse err for 1 cycle.
REQ-017 SHALL implement loader FSM states IDLE, LOAD, FLUSH, DONE.
REQ-018 IDLE->LOAD on ld_start: latch ld_base word-aligned into the load pointer; clear byte counter and ld_sum; ld_start ignored outside IDLE.
REQ-019 In LOAD, ld_ready = 1, and SHALL accept a byte on ld_valid && ld_ready, packing little-endian (first byte -> bits 7:0).
REQ-020 On the DW/8-th byte, SHALL write the full word at the pointer in the next cycle, advance the pointer by DW/8, and clear the byte counter.
REQ-021 On ld_last accepted: a completed word -> DONE; a partial word -> FLUSH, zero-fill the remaining bytes, write, then DONE.
REQ-022 In FLUSH and DONE, ld_ready = 0.
REQ-023 DONE SHALL pulse ld_done for 1 cycle, then go to IDLE; ld_busy = 1 in LOAD/FLUSH/DONE.
REQ-024 While ld_busy, SHALL ignore external wen without pulsing err; reads remain serviced.
REQ-025 Loader writes past MEM_NUM SHALL be dropped with an err pulse, and loading SHALL continue.
REQ-026 The pointer SHALL wrap modulo 2^AW; no other wrap.

Reset
REQ-027 SHALL, with rstn low at a clk edge: FSM -> IDLE; r_valid, r_data, ld_ready, ld_busy, ld_done, err, ld_sum, byte counter and pointer -> 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-load SHALL discard the partial word, which is never written.

Configuration
REQ-030 SHALL, with PROG_MEM_CHKSUM_EN defined: make ld_sum the modulo-2^DW sum of every word written by the loader (including zero-filled words), valid from the ld_done cycle until the next ld_start.
REQ-031 SHALL, without PROG_MEM_CHKSUM_EN: tie ld_sum to 0, with no adder logic present.

Structure
REQ-032 SHALL place the FSM state encoding and the byte-per-word constant in the shared package prog_mem_pkg.
REQ-033 SHALL hold storage in one instance of the existing dual_ram sub-module, extended with a byte-strobe input; the loader FSM is inline.

Verification
REQ-034 wen=1, w_addr=0x8, w_data=0xAABBCCDD, w_strb=4'b0101; then ren at 0x8 -> r_data=0x00BB00DD (from 0 init), r_valid 1 cycle later.
REQ-035 ld_base=0x10, bytes 11,22,33,44,55 (last on 55) -> word4=0x44332211, word5=0x00000055, ld_done 1 pulse; with macro ld_sum=0x44332266.
REQ-036 Read at 0x4000 (MEM_NUM=4096) -> r_data=0, r_valid=1, err pulse.
REQ-037 rstn low after 2 of 4 bytes -> FSM IDLE, target word unchanged, all outputs 0.
REQ-038 External wen with ld_busy=1 -> memory unchanged, no err.
